// File: rtl/serial_adder_mux_if.sv
// Operand/result bundle for serial_adder_mux. The master side requests an
// operation; the slave side (the adder) reports progress and the result.
interface serial_adder_mux_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_mux.sv
// Bit-serial adder/subtractor. One bit per cycle, LSB first; the sum bit and
// the next carry are each picked by a 4:1 mux indexed by the operand bit pair.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; operands and mode captured on accept
// RUN   | one bit processed per cycle, WIDTH cycles, busy=1
// DONE  | single cycle, done=1, result registers just updated
module serial_adder_mux #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_mux_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             last_bit;
    logic [1:0]       sel;
    logic [3:0]       sum_data;
    logic [3:0]       carry_data;
    logic             s_bit;
    logic             c_nxt;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Per-bit full adder realised as two 4:1 muxes selected by {a_i, b_i}.
    always_comb begin
        sel           = {op_a[0], op_b[0]};
        sum_data[0]   = carry;
        sum_data[1]   = ~carry;
        sum_data[2]   = ~carry;
        sum_data[3]   = carry;
        carry_data[0] = 1'b0;
        carry_data[1] = carry;
        carry_data[2] = carry;
        carry_data[3] = 1'b1;
        s_bit         = sum_data[sel];
        c_nxt         = carry_data[sel];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore status outputs decoded from the state.
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // Operand capture, serial datapath and result registers. Subtraction is
    // a + ~b + 1, so b is inverted on capture and the carry seeded with mode.
    // In the last RUN cycle the carry flop holds the carry into the MSB,
    // which is what the overflow flag compares against the carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a  <= bus.a;
                        op_b  <= bus.mode ? ~bus.b : bus.b;
                        carry <= bus.mode;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= {1'b0, op_a[WIDTH-1:1]};
                    op_b  <= {1'b0, op_b[WIDTH-1:1]};
                    res   <= {s_bit, res[WIDTH-1:1]};
                    carry <= c_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        bus.sum  <= {s_bit, res[WIDTH-1:1]};
                        bus.cout <= c_nxt;
                        bus.ovf  <= carry ^ c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_mux.sv
// Bench for serial_adder_mux: an operation-level reference model predicts
// busy/done timing and the result registers each cycle; directed operations
// also check literal results, latency and pulse counts.
module tb_serial_adder_mux;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_mux_if #(.WIDTH(W)) bus ();

    serial_adder_mux #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (operation granularity, not RTL state).
    int         cyc = 0;
    bit         model_valid = 1'b0;
    bit         active = 1'b0;
    int         acc = 0;
    logic [W-1:0] pend_sum, exp_sum;
    logic         pend_cout, pend_ovf, exp_cout, exp_ovf;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Arithmetic definition of the result: unsigned carry/no-borrow and
    // signed overflow from operand and result signs.
    task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] t;
        if (!m) begin
            t  = {1'b0, a} + {1'b0, b};
            s  = t[W-1:0];
            co = t[W];
            ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s  = a - b;
            co = (a >= b);
            ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
    endtask

    // Model update at each edge; cyc is the index of the cycle ending here.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            model_valid = 1'b1;
            active      = 1'b0;
            exp_sum     = '0;
            exp_cout    = 1'b0;
            exp_ovf     = 1'b0;
        end else if (active) begin
            if (cyc == acc + W) begin
                exp_sum  = pend_sum;
                exp_cout = pend_cout;
                exp_ovf  = pend_ovf;
            end
            if (cyc == acc + W + 1) active = 1'b0;
        end else if (bus.start === 1'b1) begin
            active = 1'b1;
            acc    = cyc;
            ref_op(bus.a, bus.b, bus.mode, pend_sum, pend_cout, pend_ovf);
        end
        cyc++;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic exp_busy, exp_done;
        if (model_valid) begin
            exp_busy = active && (cyc >= acc + 1) && (cyc <= acc + W);
            exp_done = active && (cyc == acc + W + 1);
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("done", 32'(bus.done), 32'(exp_done));
            chk("sum",  32'(bus.sum),  32'(exp_sum));
            chk("cout", 32'(bus.cout), 32'(exp_cout));
            chk("ovf",  32'(bus.ovf),  32'(exp_ovf));
        end
    end

    // Called at a negedge while the DUT is idle; drives start immediately.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input bit interfere);
        logic [W-1:0] ms;
        logic         mc, mo;
        int           c0, dc, nb, nd;
        ref_op(a, b, m, ms, mc, mo);
        chk("model_sum",  32'(ms), 32'(es));
        chk("model_cout", 32'(mc), 32'(ec));
        chk("model_ovf",  32'(mo), 32'(eo));
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.mode  = m;
        c0        = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.mode  = 1'($urandom);
        nb = 0;
        nd = 0;
        dc = -1;
        for (int i = 0; i < W + 6; i++) begin
            if (interfere && cyc == c0 + 3) begin
                bus.start = 1'b1;
                bus.a     = ~a;
                bus.b     = a;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy === 1'b1) nb++;
            if (bus.done === 1'b1) begin
                nd++;
                if (dc < 0) dc = cyc;
            end
            @(negedge clk);
        end
        chk("latency",     32'(dc - c0), 32'(W + 1));
        chk("busy_cycles", 32'(nb), 32'(W));
        chk("done_pulses", 32'(nd), 32'd1);
        chk("op_sum",      32'(bus.sum),  32'(es));
        chk("op_cout",     32'(bus.cout), 32'(ec));
        chk("op_ovf",      32'(bus.ovf),  32'(eo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, nd;
        int dq[$];
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'd0);

        // First start on the first edge after reset release.
        rst = 1'b0;
        run_op(8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op(8'h21, 8'h13, 1'b0, 8'h34, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a run aborts it.
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.mode  = 1'b0;
        c0        = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < c0 + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_sum",  32'(bus.sum),  32'd0);
        nd = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (bus.done === 1'b1) nd++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        // Start held high: back-to-back operations every W+2 cycles.
        c0 = cyc;
        for (int i = 0; i < 30; i++) begin
            bus.start = 1'b1;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.mode  = 1'($urandom);
            if (bus.done === 1'b1) dq.push_back(cyc - c0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("stream_dones", 32'(dq.size()), 32'd3);
        if (dq.size() == 3) begin
            chk("stream_done0", 32'(dq[0]), 32'd9);
            chk("stream_done1", 32'(dq[1]), 32'd19);
            chk("stream_done2", 32'(dq[2]), 32'd29);
        end
        repeat (W + 3) @(negedge clk);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            bus.start = ($urandom_range(0, 2) != 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.mode  = 1'($urandom);
            @(negedge clk);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
